ps2_key_ctrl: RTL and testbench

- Sequences the raw scan-code stream from the PS/2 frame decoder into a clean key-event stream for the CPU.
- Runs the set-2 prefix state machine (E0 extended, F0 break) and tracks modifier state: L/R shift, L/R ctrl, caps-lock toggle.
- Translates make codes to ASCII and buffers the results in a small FIFO read by the CPU MMIO keyboard register.
- Sits between ps2_decoder (code/code_valid) and the CPU bus slave.

---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_ascii_lut.sv | 103 ++++++++++
 rtl/ps2_key_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 key controller.
//   * Set-2 prefix / protocol codes (E0, F0, E1, AA, FA, FE, plus 00/FF)
//   * Modifier make codes (shift, ctrl, caps-lock)
//   * Navigation output codes placed in the key FIFO (0x80..0x83)
//   * Prefix FSM state encoding
package ps2_pkg;

    // Prefix and protocol codes
    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] CODE_E1   = 8'hE1;
    localparam logic [7:0] CODE_BAT  = 8'hAA;
    localparam logic [7:0] CODE_ACK  = 8'hFA;
    localparam logic [7:0] CODE_RSND = 8'hFE;
    localparam logic [7:0] CODE_ERR0 = 8'h00;
    localparam logic [7:0] CODE_ERRF = 8'hFF;

    // Modifier make codes
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CTRL   = 8'h14;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    // Navigation key outputs
    localparam logic [7:0] NAV_UP    = 8'h80;
    localparam logic [7:0] NAV_DOWN  = 8'h81;
    localparam logic [7:0] NAV_LEFT  = 8'h82;
    localparam logic [7:0] NAV_RIGHT = 8'h83;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    // Protocol bytes that never belong to a key sequence and must not disturb
    // the prefix state.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == CODE_E1)  || (code == CODE_BAT)  || (code == CODE_ACK) ||
               (code == CODE_RSND) || (code == CODE_ERR0) || (code == CODE_ERRF);
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut -- combinational set-2 scan code to ASCII translation.
// Ports:
//   code_i   [7:0]  make code (prefix already stripped)
//   ext_i           code was preceded by E0
//   shift_i         either shift held
//   caps_i          caps-lock active
//   ctrl_i          either ctrl held
//   ascii_o  [7:0]  translated character / nav code, 0x00 = unmapped
module ps2_ascii_lut
    import ps2_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       ext_i,
    input  logic       shift_i,
    input  logic       caps_i,
    input  logic       ctrl_i,
    output logic [7:0] ascii_o
);

    logic [7:0] letter;    // lowercase letter, 0 if code is not a letter
    logic [7:0] plain;     // unshifted form of a non-letter
    logic [7:0] shifted;   // shifted form of a non-letter

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        letter = 8'h00;
        case (code_i)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            default: letter = 8'h00;
        endcase
    end

    always_comb begin
        plain   = 8'h00;
        shifted = 8'h00;
        case (code_i)
            8'h16: begin plain = "1";   shifted = "!";   end
            8'h1E: begin plain = "2";   shifted = "@";   end
            8'h26: begin plain = "3";   shifted = "#";   end
            8'h25: begin plain = "4";   shifted = "$";   end
            8'h2E: begin plain = "5";   shifted = "%";   end
            8'h36: begin plain = "6";   shifted = "^";   end
            8'h3D: begin plain = "7";   shifted = "&";   end
            8'h3E: begin plain = "8";   shifted = "*";   end
            8'h46: begin plain = "9";   shifted = "(";   end
            8'h45: begin plain = "0";   shifted = ")";   end
            8'h0E: begin plain = 8'h60; shifted = "~";   end
            8'h4E: begin plain = "-";   shifted = "_";   end
            8'h55: begin plain = "=";   shifted = "+";   end
            8'h54: begin plain = "[";   shifted = "{";   end
            8'h5B: begin plain = "]";   shifted = "}";   end
            8'h5D: begin plain = 8'h5C; shifted = "|";   end
            8'h4C: begin plain = ";";   shifted = ":";   end
            8'h52: begin plain = 8'h27; shifted = 8'h22; end
            8'h41: begin plain = ",";   shifted = "<";   end
            8'h49: begin plain = ".";   shifted = ">";   end
            8'h4A: begin plain = "/";   shifted = "?";   end
            // Control keys are unaffected by shift
            8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
            8'h66: begin plain = 8'h08; shifted = 8'h08; end
            8'h0D: begin plain = 8'h09; shifted = 8'h09; end
            8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
            8'h29: begin plain = 8'h20; shifted = 8'h20; end
            default: begin plain = 8'h00; shifted = 8'h00; end
        endcase
    end

    always_comb begin
        ascii_o = 8'h00;
        if (ext_i) begin
            // Extended keys: only the navigation cluster is mapped
            case (code_i)
                8'h75:   ascii_o = NAV_UP;
                8'h72:   ascii_o = NAV_DOWN;
                8'h6B:   ascii_o = NAV_LEFT;
                8'h74:   ascii_o = NAV_RIGHT;
                8'h71:   ascii_o = 8'h7F;
                8'h5A:   ascii_o = 8'h0D;
                default: ascii_o = 8'h00;
            endcase
        end else if (letter != 8'h00) begin
            // 'a' is 0x61; subtracting 0x60 gives control codes 0x01..0x1A
            if (ctrl_i)
                ascii_o = letter - 8'h60;
            else if (shift_i ^ caps_i)
                ascii_o = letter - 8'h20;
            else
                ascii_o = letter;
        end else begin
            ascii_o = shift_i ? shifted : plain;
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl -- turns the raw PS/2 set-2 scan code stream into key events.
// Runs the E0/F0 prefix FSM, tracks shift/ctrl/caps, translates makes through
// ps2_ascii_lut and buffers results in a show-ahead FIFO for the CPU.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   code_in/code_valid scan code byte and its one-cycle strobe
//   rd_en             pop the FIFO head (ignored while empty)
//   clr_ovf           clear the sticky overflow flag
//   key_data          FIFO head, 0x00 when empty
//   key_avail         FIFO not empty
//   key_count         FIFO occupancy
//   overflow          sticky: a key was dropped on a full FIFO
//   shift_o/ctrl_o/caps_o  modifier state
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       code_in,
    input  logic             code_valid,
    input  logic             rd_en,
    input  logic             clr_ovf,
    output logic [7:0]       key_data,
    output logic             key_avail,
    output logic [CNT_W-1:0] key_count,
    output logic             overflow,
    output logic             shift_o,
    output logic             ctrl_o,
    output logic             caps_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    ps2_state_e state_q, state_d;
    logic lshift_q, lshift_d, rshift_q, rshift_d;
    logic lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic caps_q, caps_d;
    logic push_req;
    logic is_ext;
    logic [7:0] ascii;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             do_pop, do_push, drop;

    assign is_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

    ps2_ascii_lut u_lut (
        .code_i  (code_in),
        .ext_i   (is_ext),
        .shift_i (lshift_q | rshift_q),
        .caps_i  (caps_q),
        .ctrl_i  (lctrl_q | rctrl_q),
        .ascii_o (ascii)
    );

    // ---------------- prefix FSM and modifier tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            lctrl_q  <= 1'b0;
            rctrl_q  <= 1'b0;
            caps_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            lctrl_q  <= lctrl_d;
            rctrl_q  <= rctrl_d;
            caps_q   <= caps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        lctrl_d  = lctrl_q;
        rctrl_d  = rctrl_q;
        caps_d   = caps_q;
        push_req = 1'b0;
        if (code_valid && !is_ignored(code_in)) begin
            case (state_q)
                ST_IDLE, ST_EXT: begin
                    if (code_in == CODE_BRK) begin
                        state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
                    end else if (code_in == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                        case (code_in)
                            CODE_LSHIFT: lshift_d = 1'b1;
                            CODE_RSHIFT: rshift_d = 1'b1;
                            CODE_CTRL: begin
                                if (is_ext) rctrl_d = 1'b1;
                                else        lctrl_d = 1'b1;
                            end
                            CODE_CAPS:   caps_d = ~caps_q;
                            default:     push_req = (ascii != 8'h00);
                        endcase
                    end
                end
                default: begin // ST_BRK, ST_EXT_BRK
                    state_d = ST_IDLE;
                    case (code_in)
                        CODE_LSHIFT: lshift_d = 1'b0;
                        CODE_RSHIFT: rshift_d = 1'b0;
                        CODE_CTRL: begin
                            if (is_ext) rctrl_d = 1'b0;
                            else        lctrl_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign shift_o = lshift_q | rshift_q;
    assign ctrl_o  = lctrl_q | rctrl_q;
    assign caps_o  = caps_q;

    // ---------------- key FIFO ----------------
    assign do_pop  = rd_en && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_req && ((count_q != FULL_CNT) || do_pop);
    assign drop    = push_req && !do_push;

    // NOTE: the storage array has no reset; entries are only observable once
    // written, and leaving it out of reset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= ascii;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
            // A drop in the same cycle as clr_ovf wins.
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

    assign key_avail = (count_q != '0);
    assign key_data  = key_avail ? mem_q[rd_ptr_q] : 8'h00;
    assign key_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: inputs change and outputs are sampled on the
// falling clock edge, away from the active rising edge.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] code_in;
    logic       code_valid;
    logic       rd_en;
    logic       clr_ovf;
    logic [7:0] key_data;
    logic       key_avail;
    logic [3:0] key_count;
    logic       overflow;
    logic       shift_o, ctrl_o, caps_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .rd_en      (rd_en),
        .clr_ovf    (clr_ovf),
        .key_data   (key_data),
        .key_avail  (key_avail),
        .key_count  (key_count),
        .overflow   (overflow),
        .shift_o    (shift_o),
        .ctrl_o     (ctrl_o),
        .caps_o     (caps_o)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle code strobe, starting and ending on a falling edge.
    task automatic send(input logic [7:0] c);
        code_in    = c;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        code_in    = 8'h00;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Check the head value, then pop it.
    task automatic expect_pop(input string tag, input logic [7:0] exp);
        check(tag, {8'h00, key_data}, {8'h00, exp});
        pop();
    endtask

    logic [7:0] fill_codes [9];
    logic [7:0] drain_exp  [8];

    initial begin
        fill_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        drain_exp  = '{"b", "c", "d", "e", "f", "g", "h", "j"};

        rst_n = 1'b0; code_in = 8'h00; code_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_key_data", {8'h00, key_data}, 16'h0000);
        check("rst_key_avail", {15'd0, key_avail}, 16'd0);
        check("rst_key_count", {12'd0, key_count}, 16'd0);
        check("rst_overflow", {15'd0, overflow}, 16'd0);
        check("rst_mods", {13'd0, shift_o, ctrl_o, caps_o}, 16'd0);

        // Make + break of 'a': one entry only
        send(8'h1C); send(8'hF0); send(8'h1C);
        check("a_count", {12'd0, key_count}, 16'd1);
        check("a_data", {8'h00, key_data}, 16'h0061);
        pop();
        check("a_pop_avail", {15'd0, key_avail}, 16'd0);
        check("a_pop_data", {8'h00, key_data}, 16'h0000);

        // Shifted letter, then released shift
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        check("shift_count", {12'd0, key_count}, 16'd2);
        check("shift_released", {15'd0, shift_o}, 16'd0);
        expect_pop("shift_A", 8'h41);
        expect_pop("shift_a", 8'h61);

        // Caps-lock makes letters uppercase
        send(8'h58); send(8'h1C);
        check("caps_on", {15'd0, caps_o}, 16'd1);
        expect_pop("caps_A", 8'h41);

        // Shift+caps digit: caps ignored for digits
        send(8'h12); send(8'h16);
        check("shift_held", {15'd0, shift_o}, 16'd1);
        expect_pop("shift_1", 8'h21);
        // Shift+caps on a letter cancels to lowercase
        send(8'h1C);
        expect_pop("shift_caps_a", 8'h61);
        send(8'hF0); send(8'h12); send(8'h58);
        check("caps_off", {13'd0, shift_o, ctrl_o, caps_o}, 16'd0);

        // Extended nav key, right ctrl + letter
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h14);
        check("rctrl_on", {15'd0, ctrl_o}, 16'd1);
        send(8'h21);
        send(8'hE0); send(8'hF0); send(8'h14);
        check("rctrl_off", {15'd0, ctrl_o}, 16'd0);
        check("nav_count", {12'd0, key_count}, 16'd2);
        expect_pop("nav_up", 8'h80);
        expect_pop("ctrl_c", 8'h03);
        send(8'h1C);                         // proves FSM back in IDLE
        expect_pop("idle_after_ext", 8'h61);

        // Overflow: nine keys into an eight-deep FIFO
        for (int i = 0; i < 8; i++) send(fill_codes[i]);
        check("fill_count8", {12'd0, key_count}, 16'd8);
        check("fill_no_ovf", {15'd0, overflow}, 16'd0);
        send(fill_codes[8]);
        check("ovf_count", {12'd0, key_count}, 16'd8);
        check("ovf_set", {15'd0, overflow}, 16'd1);
        check("ovf_head", {8'h00, key_data}, 16'h0061);
        // Modifiers still tracked while full
        send(8'h12);
        check("full_shift_on", {15'd0, shift_o}, 16'd1);
        send(8'hF0); send(8'h12);
        check("full_shift_off", {15'd0, shift_o}, 16'd0);
        // clr_ovf coinciding with a drop: set wins
        clr_ovf = 1'b1;
        send(8'h42);
        clr_ovf = 1'b0;
        check("clr_vs_drop", {15'd0, overflow}, 16'd1);
        // Push + pop while full
        rd_en = 1'b1;
        send(8'h3B);
        rd_en = 1'b0;
        check("pushpop_count", {12'd0, key_count}, 16'd8);
        check("pushpop_head", {8'h00, key_data}, {8'h00, 8'h62});
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", {15'd0, overflow}, 16'd0);
        for (int i = 0; i < 8; i++) expect_pop($sformatf("drain_%0d", i), drain_exp[i]);
        check("drain_empty", {12'd0, key_count}, 16'd0);

        // Reset mid-prefix with shift held
        send(8'h12); send(8'hE0); send(8'hF0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_mods", {13'd0, shift_o, ctrl_o, caps_o}, 16'd0);
        send(8'h75);
        check("rst_mid_drop75", {12'd0, key_count}, 16'd0);
        send(8'h1C);
        expect_pop("rst_mid_idle", 8'h61);

        // Ignored protocol bytes and pop while empty
        pop();
        check("empty_pop_count", {12'd0, key_count}, 16'd0);
        send(8'hFA); send(8'hAA);
        check("ignored_count", {12'd0, key_count}, 16'd0);
        send(8'hE0); send(8'hFA); send(8'h75);   // FA inside a prefix keeps EXT
        check("ignored_mid_ext", {12'd0, key_count}, 16'd1);
        expect_pop("ignored_nav", 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
